egd_bitstream_encoder: RTL and testbench

Exp-Golomb encoder: the transmit-side counterpart of the egd_top decoder. It turns syntax-element values into ue(v), se(v) or te(v) codewords and packs them MSB-first into 16-bit bitstream words. Each output word is in the same format the decoder's BitStream_buffer_input consumes. Input and output both use valid/ready handshakes, and a flush appends the RBSP stop bit and zero-pads to a word boundary.

---
 rtl/egd_bitstream_encoder.sv | 130 +++++++++++++
 tb/tb_egd_bitstream_encoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/egd_bitstream_encoder.sv
// Exp-Golomb (ue/se/te) encoder packing codewords MSB-first into 16-bit words.
// Flush appends the RBSP stop bit and zero-pads to the next word boundary.
module egd_bitstream_encoder #(
  parameter int OUT_W = 16,
  parameter int ACC_W = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] code_num,
  input  logic [1:0]  exp_golomb_sel,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_word,
  output logic [6:0]  fill_count,
  output logic        flush_done,
  output logic [15:0] word_count
);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [6:0]         fill_q, fill_d;
  logic [15:0]        wc_q, wc_d;
  logic               flush_done_q, flush_done_d;

  logic signed [17:0] v18;
  logic signed [17:0] k18;
  logic [16:0]        k;
  logic [17:0]        kp1;
  logic [4:0]         m;
  logic [5:0]         len;
  logic [32:0]        code;

  logic               accept_sym, accept_flush, drain;
  logic [6:0]         fill_after;
  logic [ACC_W-1:0]   acc_after;

  assign in_ready   = (state_q == S_RUN) && (fill_q < 7'(OUT_W)) && !rst;
  assign out_valid  = (fill_q >= 7'(OUT_W));
  assign out_word   = acc_q[ACC_W-1 -: OUT_W];
  assign fill_count = fill_q;
  assign word_count = wc_q;
  assign flush_done = flush_done_q;

  assign accept_sym   = in_valid & in_ready;
  assign accept_flush = flush & in_ready;
  assign drain        = out_valid & out_ready;

  // Codeword: M leading zeros followed by k+1 is just k+1 in a (2M+1)-bit field.
  always_comb begin
    v18  = {{2{code_num[15]}}, code_num};
    k18  = 18'sd0;
    k    = {1'b0, code_num};
    case (exp_golomb_sel)
      2'b01: begin
        if ($signed(code_num) > 16'sd0) k18 = (v18 <<< 1) - 18'sd1;
        else                            k18 = 18'sd0 - (v18 <<< 1);
        k = k18[16:0];
      end
      default: k = {1'b0, code_num};
    endcase
    kp1 = {1'b0, k} + 18'd1;
    m = 5'd0;
    for (int i = 0; i < 18; i++) begin
      if (kp1[i]) m = 5'(i);
    end
    len  = 6'({m, 1'b0}) + 6'd1;
    code = 33'(kp1);
    if (exp_golomb_sel == 2'b10) begin
      len  = 6'd1;
      code = {32'd0, ~code_num[0]};
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    fill_d       = fill_q;
    wc_d         = wc_q;
    flush_done_d = 1'b0;
    acc_after    = acc_q;
    fill_after   = fill_q;

    if (accept_sym) begin
      acc_after  = acc_q | (ACC_W'(code) << (7'(ACC_W) - fill_q - 7'(len)));
      fill_after = fill_q + 7'(len);
    end

    if (accept_flush) begin
      // Stop bit goes right below the symbol; rounding (f+1) up to a word is (f+16) & ~15.
      acc_after  = acc_after | (ACC_W'(1) << (7'(ACC_W - 1) - fill_after));
      fill_after = (fill_after + 7'(OUT_W)) & ~7'(OUT_W - 1);
      state_d    = S_FLUSH;
    end

    if (accept_sym || accept_flush) begin
      acc_d  = acc_after;
      fill_d = fill_after;
    end else if (drain) begin
      acc_d  = acc_q << OUT_W;
      fill_d = fill_q - 7'(OUT_W);
      wc_d   = wc_q + 16'd1;
      if (state_q == S_FLUSH && fill_q == 7'(OUT_W)) begin
        state_d      = S_RUN;
        flush_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_RUN;
      acc_q        <= '0;
      fill_q       <= '0;
      wc_q         <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      wc_q         <= wc_d;
      flush_done_q <= flush_done_d;
    end
  end

endmodule

// File: tb/tb_egd_bitstream_encoder.sv
// Directed bench for egd_bitstream_encoder: hand-computed codeword streams,
// flush padding, back-pressure and asynchronous reset.
module tb_egd_bitstream_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] code_num;
  logic [1:0]  exp_golomb_sel;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_word;
  logic [6:0]  fill_count;
  logic        flush_done;
  logic [15:0] word_count;

  int n_vec  = 0;
  int n_miss = 0;
  int fd_cnt = 0;
  logic [15:0] words [$];
  logic [15:0] exp_q [$];

  egd_bitstream_encoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .code_num(code_num), .exp_golomb_sel(exp_golomb_sel), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .fill_count(fill_count), .flush_done(flush_done), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Words transfer on the following rising edge; inputs only move at posedge+1.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) words.push_back(out_word);
    if (!rst && flush_done) fd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic wait_accept();
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic send(input logic [1:0] sel, input logic [15:0] val,
                      input logic v, input logic fl);
    exp_golomb_sel = sel;
    code_num       = val;
    in_valid       = v;
    flush          = fl;
    wait_accept();
  endtask

  task automatic wait_flush(input string tag);
    int t = 0;
    int start = fd_cnt;
    while (fd_cnt == start && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk({tag, "_flush_done"}, 32'(fd_cnt - start), 32'd1);
    chk({tag, "_fd_one_cycle"}, 32'(flush_done), 32'd0);
    chk({tag, "_fill_zero"}, 32'(fill_count), 32'd0);
  endtask

  task automatic chk_words(input string tag);
    chk({tag, "_nwords"}, 32'(words.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), (i < words.size()) ? 32'(words[i]) : 32'hDEAD_BEEF,
          32'(exp_q[i]));
    words.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    words.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    exp_golomb_sel = 2'b00; code_num = 16'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_word", 32'(out_word), 32'h0000);
    chk("rst_fill", 32'(fill_count), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    chk("rst_fd", 32'(flush_done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // ue 0,1,2,3 + flush: 1 010 011 00100 1 000
    send(2'b00, 16'd0, 1'b1, 1'b0);
    send(2'b00, 16'd1, 1'b1, 1'b0);
    send(2'b00, 16'd2, 1'b1, 1'b0);
    send(2'b00, 16'd3, 1'b1, 1'b0);
    chk("t1_fill12", 32'(fill_count), 32'd12);
    send(2'b00, 16'd0, 1'b0, 1'b1);
    wait_flush("t1");
    exp_q.push_back(16'hA648);
    chk_words("t1");
    chk("t1_wc", 32'(word_count), 32'd1);

    // se -1,+1,0 + flush, then se -32768 (k+1 = 0x10001, 33 bits) + flush
    do_reset();
    send(2'b01, 16'hFFFF, 1'b1, 1'b0);
    send(2'b01, 16'd1, 1'b1, 1'b0);
    send(2'b01, 16'd0, 1'b1, 1'b0);
    send(2'b00, 16'd0, 1'b0, 1'b1);
    wait_flush("t2a");
    exp_q.push_back(16'h6B00);
    chk_words("t2a");
    send(2'b01, 16'h8000, 1'b1, 1'b0);
    send(2'b00, 16'd0, 1'b0, 1'b1);
    wait_flush("t2b");
    exp_q.push_back(16'h0000); exp_q.push_back(16'h8000); exp_q.push_back(16'hC000);
    chk_words("t2b");
    chk("t2_wc", 32'(word_count), 32'd4);

    // ue 65535: 16 zeros, 1, 16 zeros
    do_reset();
    send(2'b00, 16'hFFFF, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("t3_fill1", 32'(fill_count), 32'd1);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h8000);
    chk_words("t3a");
    send(2'b00, 16'd0, 1'b0, 1'b1);
    wait_flush("t3");
    exp_q.push_back(16'h4000);
    chk_words("t3b");
    chk("t3_wc", 32'(word_count), 32'd3);

    // te: code_num[15:1] ignored, bit = ~code_num[0]; alternate starting with 0
    do_reset();
    for (int i = 0; i < 16; i++)
      send(2'b10, (i % 2 == 0) ? 16'hFFFF : 16'hFFFE, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(16'h5555);
    chk_words("t4");
    chk("t4_wc", 32'(word_count), 32'd1);
    chk("t4_fill", 32'(fill_count), 32'd0);

    // back-pressure: three ue 65535 with out_ready low
    do_reset();
    out_ready = 1'b0;
    send(2'b00, 16'hFFFF, 1'b1, 1'b0);
    exp_golomb_sel = 2'b00; code_num = 16'hFFFF; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_in_ready_low", 32'(in_ready), 32'd0);
      chk("t5_word_held", 32'(out_word), 32'h0000);
      chk("t5_fill33", 32'(fill_count), 32'd33);
    end
    chk("t5_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept();
    send(2'b00, 16'hFFFF, 1'b1, 1'b0);
    send(2'b00, 16'd0, 1'b0, 1'b1);
    wait_flush("t5");
    exp_q.push_back(16'h0000); exp_q.push_back(16'h8000); exp_q.push_back(16'h0000);
    exp_q.push_back(16'h4000); exp_q.push_back(16'h0000); exp_q.push_back(16'h2000);
    exp_q.push_back(16'h1000);
    chk_words("t5");
    chk("t5_wc", 32'(word_count), 32'd7);

    // reset in FLUSH with pending bits: ue 30, then ue 30 + flush -> 32 bits
    out_ready = 1'b0;
    send(2'b00, 16'd30, 1'b1, 1'b0);
    send(2'b00, 16'd30, 1'b1, 1'b1);
    chk("t6_fill32", 32'(fill_count), 32'd32);
    chk("t6_in_ready_flush", 32'(in_ready), 32'd0);
    chk("t6_word0", 32'(out_word), 32'h0F87);
    rst = 1'b1;
    #2;
    chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_fill", 32'(fill_count), 32'd0);
    chk("t6_rst_wc", 32'(word_count), 32'd0);
    chk("t6_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("t6_run_in_ready", 32'(in_ready), 32'd1);
    chk_words("t6_discard");
    send(2'b00, 16'd0, 1'b1, 1'b1);
    wait_flush("t6");
    exp_q.push_back(16'hC000);
    chk_words("t6");
    chk("t6_wc", 32'(word_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
